// File: rtl/riscv_pkg.sv
// Shared front-end constants: datapath width, canonical NOP, reset vector.
package riscv_pkg;
    localparam int          XLEN       = 32;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, address} pairs.
// The head entry is read straight from the storage array, so rdata is purely
// registered state.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = 2 * riscv_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Data storage; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the PC, issues fetches to a fixed-latency
// ROM under a credit limit, tracks in-flight requests, and buffers returned
// words for decode. A jump flushes the queue and kills in-flight responses.
module ifetch_queue
    import riscv_pkg::*;
#(
    parameter int                      XLEN       = riscv_pkg::XLEN,
    parameter int                      DEPTH      = 4,
    parameter int                      ROM_LAT    = 1,
    parameter logic [XLEN-1:0]         RESET_ADDR = XLEN'(riscv_pkg::RESET_ADDR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_addr,
    output logic [XLEN-1:0] pc2rom,
    output logic            rom_req,
    input  logic [XLEN-1:0] rom_ins,
    output logic [XLEN-1:0] ins,
    output logic [XLEN-1:0] ins_addr,
    output logic            ins_valid
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [XLEN-1:0]               pc;
    logic [ROM_LAT-1:0]            pipe_vld;
    logic [ROM_LAT-1:0][XLEN-1:0]  pipe_addr;
    logic [CW-1:0]                 inflight;
    logic [CW-1:0]                 count;
    logic                          empty;
    logic                          full;
    logic                          push;
    logic                          pop;
    logic [2*XLEN-1:0]             head;

    // Number of requests issued whose ROM response has not yet landed.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) inflight = inflight + CW'(pipe_vld[i]);
    end

    // Credit check counts queued plus in-flight words and ignores a same-cycle
    // pop, so a returning response always has a free slot. !full is redundant
    // with the credit check but keeps the FIFO safe on its own terms.
    assign rom_req = rst && !jump_en && !full &&
                     ((SW'(count) + SW'(inflight)) < SW'(DEPTH));
    assign pc2rom  = pc;

    assign push = pipe_vld[ROM_LAT-1];
    assign pop  = !empty && !hold;

    // PC and in-flight tracking; a jump clears every valid bit so late ROM
    // responses are never pushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_ADDR;
            pipe_vld  <= '0;
            pipe_addr <= '0;
        end else begin
            pipe_vld[0]  <= rom_req;
            pipe_addr[0] <= pc;
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_addr[k] <= pipe_addr[k-1];
            end
            if (jump_en) begin
                pipe_vld <= '0;
                pc       <= {jump_addr[XLEN-1:2], 2'b00};
            end else if (rom_req) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .wdata ({rom_ins, pipe_addr[ROM_LAT-1]}),
        .pop   (pop),
        .flush (jump_en),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // Decode-facing outputs come from the registered queue head only.
    assign ins_valid = !empty;
    assign ins       = empty ? XLEN'(INST_NOP) : head[2*XLEN-1:XLEN];
    assign ins_addr  = empty ? '0 : head[XLEN-1:0];
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: ROM model returns ~addr, scoreboard of issued
// fetches predicts issue credit, head validity and head contents each cycle.
module tb_ifetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: DEPTH=4, ROM_LAT=1
    logic        rst, hold, jump_en, rom_req, ins_valid;
    logic [31:0] jump_addr, pc2rom, rom_ins, ins, ins_addr;
    // DUT 2: DEPTH=8, ROM_LAT=3
    logic        rst2, hold2, jump_en2, rom_req2, ins_valid2;
    logic [31:0] jump_addr2, pc2rom2, rom_ins2, ins2, ins_addr2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } ent_t;
    ent_t        sb[$];
    logic [31:0] exp_pc;

    ifetch_queue #(.XLEN(32), .DEPTH(4), .ROM_LAT(1), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .hold(hold), .jump_en(jump_en), .jump_addr(jump_addr),
        .pc2rom(pc2rom), .rom_req(rom_req), .rom_ins(rom_ins),
        .ins(ins), .ins_addr(ins_addr), .ins_valid(ins_valid)
    );

    ifetch_queue #(.XLEN(32), .DEPTH(8), .ROM_LAT(3), .RESET_ADDR(32'h0)) dut2 (
        .clk(clk), .rst(rst2), .hold(hold2), .jump_en(jump_en2), .jump_addr(jump_addr2),
        .pc2rom(pc2rom2), .rom_req(rom_req2), .rom_ins(rom_ins2),
        .ins(ins2), .ins_addr(ins_addr2), .ins_valid(ins_valid2)
    );

    // ROM models: data is ~addr when valid, garbage otherwise
    logic        rv1 = 1'b0;
    logic [31:0] ra1 = '0;
    always @(posedge clk) begin
        rv1 <= rom_req;
        ra1 <= pc2rom;
    end
    assign rom_ins = rv1 ? ~ra1 : 32'hDEAD_BEEF;

    logic        rv2 [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] ra2 [3] = '{32'h0, 32'h0, 32'h0};
    always @(posedge clk) begin
        rv2[0] <= rom_req2; ra2[0] <= pc2rom2;
        rv2[1] <= rv2[0];   ra2[1] <= ra2[0];
        rv2[2] <= rv2[1];   ra2[2] <= ra2[1];
    end
    assign rom_ins2 = rv2[2] ? ~ra2[2] : 32'hDEAD_BEEF;

    // One clock of DUT 1 with scoreboard bookkeeping (push on issue, pop on consume).
    task automatic cycle(input logic h, input logic j, input logic [31:0] ja);
        logic exp_req, exp_v;
        hold = h; jump_en = j; jump_addr = ja;
        @(negedge clk);
        exp_req = !j && (sb.size() < 4);
        checks++;
        if (rom_req !== exp_req)
            $display("FAIL rom_req cyc=%0d got=%b exp=%b", cyc, rom_req, exp_req);
        if (rom_req !== exp_req) errors++;
        if (exp_req) begin
            checks++;
            if (pc2rom !== exp_pc) begin
                errors++;
                $display("FAIL pc2rom cyc=%0d got=%h exp=%h", cyc, pc2rom, exp_pc);
            end
        end
        exp_v = (sb.size() > 0) && (cyc >= sb[0].ready);
        checks++;
        if (ins_valid !== exp_v) begin
            errors++;
            $display("FAIL ins_valid cyc=%0d got=%b exp=%b", cyc, ins_valid, exp_v);
        end
        checks++;
        if (exp_v) begin
            if (ins_addr !== sb[0].addr || ins !== ~sb[0].addr) begin
                errors++;
                $display("FAIL head cyc=%0d got=%h/%h exp=%h/%h", cyc, ins_addr, ins,
                         sb[0].addr, ~sb[0].addr);
            end
        end else if (ins !== NOP || ins_addr !== 32'h0) begin
            errors++;
            $display("FAIL empty_out cyc=%0d got=%h/%h exp=%h/0", cyc, ins, ins_addr, NOP);
        end
        if (j) begin
            sb.delete();
            exp_pc = ja & 32'hFFFF_FFFC;
        end else begin
            if (exp_v && !h) void'(sb.pop_front());
            if (exp_req) begin
                sb.push_back('{exp_pc, cyc + 2});
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        checks++;
        if (ins_valid !== 1'b0 || ins !== NOP || ins_addr !== 32'h0 ||
            rom_req !== 1'b0 || pc2rom !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got v=%b ins=%h a=%h req=%b pc=%h exp v=0 ins=%h a=0 req=0 pc=0",
                     ins_valid, ins, ins_addr, rom_req, pc2rom, NOP);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        exp_pc = 32'h0;
        cyc = 0;
    endtask

    task automatic test_stream;
        int nv = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (ins_valid) nv++;
        end
        checks++;
        if (nv !== 13) begin
            errors++;
            $display("FAIL stream_valid_cycles got=%0d exp=13", nv);
        end
        checks++;
        if (ins_addr !== 32'h30) begin
            errors++;
            $display("FAIL stream_head got=%h exp=00000030", ins_addr);
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if (rom_req !== 1'b0 || ins_valid !== 1'b1 || ins_addr !== 32'h30) begin
            errors++;
            $display("FAIL hold_full got req=%b v=%b a=%h exp req=0 v=1 a=00000030",
                     rom_req, ins_valid, ins_addr);
        end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (ins_addr !== 32'h34) begin
            errors++;
            $display("FAIL hold_release got=%h exp=00000034", ins_addr);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_jump;
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h103);   // jump with pop pending, unaligned target
        checks++;
        if (ins_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_flush got v=%b exp=0", ins_valid);
        end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (ins_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_stale got v=%b exp=0", ins_valid);
        end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (ins_valid !== 1'b1 || ins_addr !== 32'h100 || ins !== ~32'h100) begin
            errors++;
            $display("FAIL jump_first got v=%b a=%h i=%h exp v=1 a=00000100 i=%h",
                     ins_valid, ins_addr, ins, ~32'h100);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h200);
        cycle(1'b0, 1'b1, 32'h300);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (ins_valid !== 1'b1 || ins_addr !== 32'h300) begin
            errors++;
            $display("FAIL jump_b2b got v=%b a=%h exp v=1 a=00000300", ins_valid, ins_addr);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap;
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (ins_valid !== 1'b1 || ins_addr !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap got v=%b a=%h exp v=1 a=00000000", ins_valid, ins_addr);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_async_reset;
        checks++;
        if (ins_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stream got v=%b exp=1", ins_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ins_valid !== 1'b0 || ins !== NOP || ins_addr !== 32'h0 ||
            rom_req !== 1'b0 || pc2rom !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got v=%b ins=%h a=%h req=%b pc=%h exp v=0 ins=%h a=0 req=0 pc=0",
                     ins_valid, ins, ins_addr, rom_req, pc2rom, NOP);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (ins_valid !== 1'b1 || ins_addr !== 32'h4) begin
            errors++;
            $display("FAIL reset_restart got v=%b a=%h exp v=1 a=00000004", ins_valid, ins_addr);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_lat3;
        int          first_req = -1;
        int          first_v   = -1;
        int          bubbles   = 0;
        logic [31:0] nxt       = 32'h0;
        @(posedge clk); #1;
        rst2 = 1'b1;
        for (int n = 0; n < 30; n++) begin
            hold2 = (n >= 12 && n < 24);
            @(negedge clk);
            if (rom_req2 && first_req < 0) first_req = n;
            if (ins_valid2) begin
                if (first_v < 0) first_v = n;
                checks++;
                if (ins_addr2 !== nxt || ins2 !== ~nxt) begin
                    errors++;
                    $display("FAIL lat3_head n=%0d got=%h/%h exp=%h/%h", n, ins_addr2, ins2, nxt, ~nxt);
                end
                if (!hold2) nxt = nxt + 32'd4;
            end else if (first_v >= 0) begin
                bubbles++;
            end
            if (n == 23) begin
                checks++;
                if (rom_req2 !== 1'b0) begin
                    errors++;
                    $display("FAIL lat3_full_req got=%b exp=0", rom_req2);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (first_req !== 0 || first_v !== 4) begin
            errors++;
            $display("FAIL lat3_latency got req@%0d valid@%0d exp req@0 valid@4", first_req, first_v);
        end
        checks++;
        if (bubbles !== 0 || nxt !== 32'd56) begin
            errors++;
            $display("FAIL lat3_throughput got bubbles=%0d next=%0d exp bubbles=0 next=56", bubbles, nxt);
        end
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; jump_en = 1'b0; jump_addr = '0;
        rst2 = 1'b0; hold2 = 1'b0; jump_en2 = 1'b0; jump_addr2 = '0;
        exp_pc = 32'h0;
        test_reset;
        test_stream;
        test_hold;
        test_jump;
        test_wrap;
        test_async_reset;
        test_lat3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
